sr_tx: RTL and testbench

SR_TX -- requirements
Module: sr_tx

---
 rtl/sr_tx.sv | 114 +++++++++++
 tb/tb_sr_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_tx.sv
// rtl/sr_tx.sv - parallel-load serial shifter driving an external shift-register chain
module sr_tx #(
    parameter int WIDTH     = 8,
    parameter int CLKDIV    = 2,
    parameter int LSB_FIRST = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load,
    output logic             o_busy,
    output logic             o_sdo,
    output logic             o_sclk,
    output logic             o_done
);
    localparam int HW = $clog2(CLKDIV + 1);
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [HW-1:0] H_LAST = HW'(CLKDIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shreg_adv;

    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        sdo_d     = sdo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // The bit on o_sdo is always the outgoing end of the register.
        shreg_adv = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);

        case (state_q)
            ST_IDLE: begin
                if (i_load) begin
                    state_d = ST_SHIFT;
                    busy_d  = 1'b1;
                    shreg_d = i_data;
                    sdo_d   = (LSB_FIRST != 0) ? i_data[0] : i_data[WIDTH-1];
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (hcnt_q == H_LAST) begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bcnt_q == B_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        sclk_d  = 1'b0;
                        sdo_d   = 1'b0;
                        done_d  = 1'b1;
                        bcnt_d  = '0;
                        shreg_d = '0;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = shreg_adv;
                        sdo_d   = (LSB_FIRST != 0) ? shreg_adv[0] : shreg_adv[WIDTH-1];
                        bcnt_d  = bcnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_busy = busy_q;
    assign o_sdo  = sdo_q;
    assign o_sclk = sclk_q;
    assign o_done = done_q;
endmodule

// File: tb/tb_sr_tx.sv
// tb/tb_sr_tx.sv - scoreboard bench for sr_tx in three parameter configurations
module tb_sr_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic [2:0] load  = '0;
    logic [2:0] busy, sdo, sclk, done;
    logic [7:0] d0 = '0;
    logic [7:0] d1 = '0;
    logic [3:0] d2 = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int rise[3];
    int busy_cnt[3];
    int done_cnt[3];
    int tog[3];
    logic [2:0] sclk_prev = '0;
    logic [2:0] held_sdo  = '0;
    logic q0[$];
    logic q1[$];
    logic q2[$];

    sr_tx #(.WIDTH(8), .CLKDIV(2), .LSB_FIRST(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d0), .i_load(load[0]),
        .o_busy(busy[0]), .o_sdo(sdo[0]), .o_sclk(sclk[0]), .o_done(done[0]));
    sr_tx #(.WIDTH(8), .CLKDIV(2), .LSB_FIRST(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d1), .i_load(load[1]),
        .o_busy(busy[1]), .o_sdo(sdo[1]), .o_sclk(sclk[1]), .o_done(done[1]));
    sr_tx #(.WIDTH(4), .CLKDIV(1), .LSB_FIRST(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d2), .i_load(load[2]),
        .o_busy(busy[2]), .o_sdo(sdo[2]), .o_sclk(sclk[2]), .o_done(done[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input int i);
        logic e;
        case (i)
            0: begin
                chk("u0_bit_expected", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin e = q0.pop_front(); chk("u0_bit", 32'(sdo[0]), 32'(e)); end
            end
            1: begin
                chk("u1_bit_expected", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin e = q1.pop_front(); chk("u1_bit", 32'(sdo[1]), 32'(e)); end
            end
            default: begin
                chk("u2_bit_expected", 32'(q2.size() != 0), 1);
                if (q2.size() != 0) begin e = q2.pop_front(); chk("u2_bit", 32'(sdo[2]), 32'(e)); end
            end
        endcase
    endtask

    // External-chain view: sample o_sdo on each o_sclk rise, hold it through the high phase.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (sclk[i] !== sclk_prev[i]) tog[i]++;
            if (sclk[i] === 1'b1 && sclk_prev[i] === 1'b0) begin
                rise[i]++;
                held_sdo[i] = sdo[i];
                pop_check(i);
            end else if (sclk[i] === 1'b1 && sclk_prev[i] === 1'b1) begin
                chk("sdo_stable_high", 32'(sdo[i]), 32'(held_sdo[i]));
            end
            if (busy[i] === 1'b1) busy_cnt[i]++;
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
                chk("done_while_busy", 32'(busy[i]), 0);
            end
            sclk_prev[i] = sclk[i];
        end
    end

    task automatic clr();
        for (int i = 0; i < 3; i++) begin
            rise[i] = 0; busy_cnt[i] = 0; done_cnt[i] = 0; tog[i] = 0;
        end
    endtask

    task automatic push_frame(input int i, input logic [7:0] d, input int w, input bit lsb);
        logic b;
        for (int k = 0; k < w; k++) begin
            b = lsb ? d[k] : d[w-1-k];
            if (i == 0) q0.push_back(b);
            else if (i == 1) q1.push_back(b);
            else q2.push_back(b);
        end
    endtask

    task automatic load_go(input int i, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (i == 0) d0 = d; else if (i == 1) d1 = d; else d2 = d[3:0];
        load[i] = 1'b1;
        @(posedge clk);
        #1;
        load[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int cyc);
        cyc = 0;
        repeat (200) begin
            @(negedge clk);
            cyc++;
            if (done[i] === 1'b1) break;
        end
    endtask

    int cyc;
    int r_snap;

    initial begin
        clr();
        // Reset state, with a load request held during reset.
        load[0] = 1'b1;
        d0 = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sclk", 32'(sclk), 0);
        chk("rst_sdo", 32'(sdo), 0);
        chk("rst_done", 32'(done), 0);

        // First load accepted on the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        push_frame(0, 8'hA5, 8, 1'b0);
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        chk("a5_busy_at_load", 32'(busy[0]), 1);
        chk("a5_first_sdo", 32'(sdo[0]), 1);
        wait_done(0, cyc);
        #1;
        chk("a5_done_cycle", cyc, 33);
        chk("a5_busy_cycles", busy_cnt[0], 32);
        chk("a5_rises", rise[0], 8);
        chk("a5_done_cnt", done_cnt[0], 1);
        chk("a5_sdo_after", 32'(sdo[0]), 0);
        chk("a5_queue_empty", q0.size(), 0);
        @(negedge clk);
        chk("a5_done_one_cycle", 32'(done[0]), 0);

        // Load ignored mid-frame.
        clr();
        push_frame(0, 8'hFF, 8, 1'b0);
        load_go(0, 8'hFF);
        repeat (8) @(posedge clk);
        #1;
        d0 = 8'h00;
        load[0] = 1'b1;
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        wait_done(0, cyc);
        #1;
        chk("ff_busy_cycles", busy_cnt[0], 32);
        chk("ff_rises", rise[0], 8);
        repeat (10) @(negedge clk);
        #1;
        chk("ff_no_second_frame", rise[0], 8);
        chk("ff_idle_busy", 32'(busy[0]), 0);

        // Back-to-back frames via load in the done cycle.
        clr();
        push_frame(0, 8'h3C, 8, 1'b0);
        load_go(0, 8'h3C);
        wait_done(0, cyc);
        d0 = 8'hC3;
        load[0] = 1'b1;
        push_frame(0, 8'hC3, 8, 1'b0);
        chk("b2b_busy_in_done", 32'(busy[0]), 0);
        @(posedge clk);
        #1;
        load[0] = 1'b0;
        chk("b2b_busy_after", 32'(busy[0]), 1);
        wait_done(0, cyc);
        #1;
        chk("b2b_busy_cycles", busy_cnt[0], 64);
        chk("b2b_rises", rise[0], 16);
        chk("b2b_done_cnt", done_cnt[0], 2);

        // Reset mid-frame aborts it.
        clr();
        push_frame(0, 8'hAA, 8, 1'b0);
        load_go(0, 8'hAA);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_sclk", 32'(sclk[0]), 0);
        chk("abort_sdo", 32'(sdo[0]), 0);
        chk("abort_done", 32'(done[0]), 0);
        chk("abort_bits_seen", rise[0], 3);
        q0.delete();
        r_snap = rise[0];
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        chk("abort_no_rises", rise[0], r_snap);
        chk("abort_no_done", done_cnt[0], 0);
        clr();
        push_frame(0, 8'h55, 8, 1'b0);
        load_go(0, 8'h55);
        wait_done(0, cyc);
        #1;
        chk("r55_rises", rise[0], 8);
        chk("r55_busy_cycles", busy_cnt[0], 32);

        // LSB-first instance.
        clr();
        push_frame(1, 8'h01, 8, 1'b1);
        load_go(1, 8'h01);
        chk("lsb_first_sdo", 32'(sdo[1]), 1);
        wait_done(1, cyc);
        #1;
        chk("lsb_done_cycle", cyc, 33);
        chk("lsb_rises", rise[1], 8);
        chk("lsb_sdo_after", 32'(sdo[1]), 0);

        // CLKDIV=1, WIDTH=4 instance.
        clr();
        push_frame(2, 8'h09, 4, 1'b0);
        load_go(2, 8'h09);
        wait_done(2, cyc);
        #1;
        chk("d1_done_cycle", cyc, 9);
        chk("d1_busy_cycles", busy_cnt[2], 8);
        chk("d1_rises", rise[2], 4);
        chk("d1_toggles", tog[2], 8);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
